// File: rtl/prog_swap_pkg.sv
// rtl/prog_swap_pkg.sv - mode encodings shared by the programmable swap array
package prog_swap_pkg;

  typedef logic [1:0] swap_mode_t;

  localparam swap_mode_t MODE_PASS = 2'b00;  // a->out_a, b->out_b
  localparam swap_mode_t MODE_SWAP = 2'b01;  // b->out_a, a->out_b
  localparam swap_mode_t MODE_BCA  = 2'b10;  // a->both
  localparam swap_mode_t MODE_BCB  = 2'b11;  // b->both

endpackage

// File: rtl/prog_swap_array_if.sv
// rtl/prog_swap_array_if.sv - config chain and data pair bus of the swap array
interface prog_swap_array_if #(
  parameter int NCH = 4
);
  import prog_swap_pkg::*;

  logic           cfg_sdi;
  logic           cfg_shift;
  logic           cfg_load;
  logic           cfg_sdo;
  logic           cfg_err;
  logic           cfg_ready;
  logic           in_valid;
  logic [NCH-1:0] in_a;
  logic [NCH-1:0] in_b;
  logic           out_valid;
  logic [NCH-1:0] out_a;
  logic [NCH-1:0] out_b;

  // Driver side: user logic / test environment
  modport master (
    output cfg_sdi, cfg_shift, cfg_load, in_valid, in_a, in_b,
    input  cfg_sdo, cfg_err, cfg_ready, out_valid, out_a, out_b
  );

  // Array side
  modport slave (
    input  cfg_sdi, cfg_shift, cfg_load, in_valid, in_a, in_b,
    output cfg_sdo, cfg_err, cfg_ready, out_valid, out_a, out_b
  );

endinterface

// File: rtl/swap_cell.sv
// rtl/swap_cell.sv - combinational router for one bit pair
module swap_cell
  import prog_swap_pkg::*;
(
  input  logic       a_i,
  input  logic       b_i,
  input  swap_mode_t mode_i,
  output logic       a_o,
  output logic       b_o
);

  // Select the source of each output bit from the channel mode
  always_comb begin
    a_o = a_i;
    b_o = b_i;
    case (mode_i)
      MODE_PASS: ;
      MODE_SWAP: begin
        a_o = b_i;
        b_o = a_i;
      end
      MODE_BCA:  b_o = a_i;
      MODE_BCB:  a_o = b_i;
      default:   ;
    endcase
  end

endmodule

// File: rtl/prog_swap_array.sv
// rtl/prog_swap_array.sv - NCH-channel swap array with serial shadow/active config
module prog_swap_array
  import prog_swap_pkg::*;
#(
  parameter int NCH     = 4,
  parameter bit OUT_REG = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  prog_swap_array_if.slave   bus
);

  localparam int             CW       = $clog2(2*NCH + 2);
  localparam logic [CW-1:0]  CNT_FULL = CW'(2*NCH);
  localparam logic [CW-1:0]  CNT_OVR  = CW'(2*NCH + 1);

  logic [2*NCH-1:0] shadow_q, shadow_d;
  logic [2*NCH-1:0] active_q, active_d;
  logic [CW-1:0]    count_q, count_d;
  logic             err_q, err_d;
  logic             cfg_ready;
  logic [NCH-1:0]   rt_a, rt_b;

  // Load is only legal once exactly one full chain of bits has been shifted
  assign cfg_ready = (count_q == CNT_FULL);

  // Config next state: shift wins over load; any load attempt restarts the count
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    count_d  = count_q;
    err_d    = 1'b0;
    if (bus.cfg_shift) begin
      shadow_d = {shadow_q[2*NCH-2:0], bus.cfg_sdi};
      if (count_q != CNT_OVR) begin
        count_d = count_q + 1'b1;
      end
    end else if (bus.cfg_load) begin
      count_d = '0;
      if (cfg_ready) begin
        active_d = shadow_q;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // Config state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      active_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  assign bus.cfg_sdo   = shadow_q[2*NCH-1];
  assign bus.cfg_err   = err_q;
  assign bus.cfg_ready = cfg_ready;

  // One router per channel, all driven from the same active word so a word never mixes modes
  for (genvar k = 0; k < NCH; k++) begin : g_cell
    swap_cell u_cell (
      .a_i    (bus.in_a[k]),
      .b_i    (bus.in_b[k]),
      .mode_i (swap_mode_t'(active_q[2*k +: 2])),
      .a_o    (rt_a[k]),
      .b_o    (rt_b[k])
    );
  end

  if (OUT_REG) begin : g_oreg
    logic [NCH-1:0] out_a_q, out_b_q;
    logic           out_valid_q;

    // Output pipeline: capture routed word on valid, hold it otherwise
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_a_q     <= '0;
        out_b_q     <= '0;
        out_valid_q <= 1'b0;
      end else begin
        out_valid_q <= bus.in_valid;
        if (bus.in_valid) begin
          out_a_q <= rt_a;
          out_b_q <= rt_b;
        end
      end
    end

    assign bus.out_a     = out_a_q;
    assign bus.out_b     = out_b_q;
    assign bus.out_valid = out_valid_q;
  end else begin : g_ocomb
    assign bus.out_a     = rt_a;
    assign bus.out_b     = rt_b;
    assign bus.out_valid = bus.in_valid;
  end

endmodule

// File: tb/tb_prog_swap_array.sv
// tb/tb_prog_swap_array.sv - self-checking bench for prog_swap_array (registered and combinational)
module tb_prog_swap_array;
  import prog_swap_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prog_swap_array_if #(.NCH(N)) ifr ();
  prog_swap_array_if #(.NCH(N)) ifc ();

  prog_swap_array #(.NCH(N), .OUT_REG(1'b1)) dut_r (.clk(clk), .rst_n(rst_n), .bus(ifr));
  prog_swap_array #(.NCH(N), .OUT_REG(1'b0)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

  assign ifc.cfg_sdi   = ifr.cfg_sdi;
  assign ifc.cfg_shift = ifr.cfg_shift;
  assign ifc.cfg_load  = ifr.cfg_load;
  assign ifc.in_valid  = ifr.in_valid;
  assign ifc.in_a      = ifr.in_a;
  assign ifc.in_b      = ifr.in_b;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state
  int           mode [N];
  bit           shreg[$];
  int           cnt;
  logic [N-1:0] e_oa, e_ob;
  logic         e_ov, e_err;

  typedef struct {
    logic [7:0] cfg;
    logic [3:0] a, b, exp_a, exp_b;
  } vec_t;
  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2*N-1:0] route(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] oa, ob;
    for (int k = 0; k < N; k++) begin
      case (mode[k])
        0: begin oa[k] = a[k]; ob[k] = b[k]; end
        1: begin oa[k] = b[k]; ob[k] = a[k]; end
        2: begin oa[k] = a[k]; ob[k] = a[k]; end
        default: begin oa[k] = b[k]; ob[k] = b[k]; end
      endcase
    end
    return {oa, ob};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) mode[k] = 0;
    shreg = {};
    repeat (2*N) shreg.push_back(1'b0);
    cnt = 0; e_oa = '0; e_ob = '0; e_ov = 1'b0; e_err = 1'b0;
  endtask

  task automatic drive(input bit sh, input bit ld, input bit sdi, input bit v,
                       input logic [N-1:0] a, input logic [N-1:0] b);
    ifr.cfg_shift = sh; ifr.cfg_load = ld; ifr.cfg_sdi = sdi;
    ifr.in_valid = v; ifr.in_a = a; ifr.in_b = b;
  endtask

  // One clock: check combinational instance before the edge, registered one after
  task automatic cycle(input bit sh, input bit ld, input bit sdi, input bit v,
                       input logic [N-1:0] a, input logic [N-1:0] b);
    logic [2*N-1:0] r;
    drive(sh, ld, sdi, v, a, b);
    #1;
    r = route(a, b);
    check("comb_out_a", ifc.out_a, r[2*N-1:N]);
    check("comb_out_b", ifc.out_b, r[N-1:0]);
    check("comb_out_valid", ifc.out_valid, v);
    if (v) begin e_oa = r[2*N-1:N]; e_ob = r[N-1:0]; end
    e_ov = v;
    e_err = 1'b0;
    if (sh) begin
      shreg.push_back(sdi);
      void'(shreg.pop_front());
      cnt = (cnt + 1 > 2*N + 1) ? 2*N + 1 : cnt + 1;
    end else if (ld) begin
      if (cnt == 2*N) begin
        for (int k = 0; k < N; k++) mode[k] = 2*shreg[2*N-2-2*k] + shreg[2*N-1-2*k];
      end else begin
        e_err = 1'b1;
      end
      cnt = 0;
    end
    @(posedge clk); #1;
    check("reg_out_a", ifr.out_a, e_oa);
    check("reg_out_b", ifr.out_b, e_ob);
    check("reg_out_valid", ifr.out_valid, e_ov);
    check("cfg_err", ifr.cfg_err, e_err);
    check("cfg_err_c", ifc.cfg_err, e_err);
    check("cfg_ready", ifr.cfg_ready, cnt == 2*N);
    check("cfg_ready_c", ifc.cfg_ready, cnt == 2*N);
    check("cfg_sdo", ifr.cfg_sdo, shreg[0]);
  endtask

  task automatic load_modes(input logic [7:0] m);
    for (int i = 7; i >= 0; i--) cycle(1'b1, 1'b0, m[i], 1'b0, '0, '0);
    check("ready_before_load", ifr.cfg_ready, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    check("load_no_err", ifr.cfg_err, 1'b0);
  endtask

  task automatic data_check(input string name, input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] xa, input logic [3:0] xb);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, a, b);
    check({name, "_reg_a"}, ifr.out_a, xa);
    check({name, "_reg_b"}, ifr.out_b, xb);
    check({name, "_comb_a"}, ifc.out_a, xa);
    check({name, "_comb_b"}, ifc.out_b, xb);
  endtask

  initial begin
    tbl[0] = '{cfg: 8'b00000000, a: 4'hA, b: 4'h5, exp_a: 4'hA, exp_b: 4'h5};
    tbl[1] = '{cfg: 8'b01010101, a: 4'hC, b: 4'h3, exp_a: 4'h3, exp_b: 4'hC};
    tbl[2] = '{cfg: 8'b11100100, a: 4'hF, b: 4'h0, exp_a: 4'b0101, exp_b: 4'b0110};
    tbl[3] = '{cfg: 8'b10101010, a: 4'h9, b: 4'h6, exp_a: 4'h9, exp_b: 4'h9};
    tbl[4] = '{cfg: 8'b11111111, a: 4'h9, b: 4'h6, exp_a: 4'h6, exp_b: 4'h6};
    tbl[5] = '{cfg: 8'b00011011, a: 4'hA, b: 4'hC, exp_a: 4'hE, exp_b: 4'hA};

    model_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    check("rst_out_a", ifr.out_a, 0);
    check("rst_out_b", ifr.out_b, 0);
    check("rst_out_valid", ifr.out_valid, 0);
    check("rst_cfg_sdo", ifr.cfg_sdo, 0);
    check("rst_cfg_ready", ifr.cfg_ready, 0);
    check("rst_cfg_err", ifr.cfg_err, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven mode vectors
    for (int i = 0; i < 6; i++) begin
      load_modes(tbl[i].cfg);
      data_check($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].exp_a, tbl[i].exp_b);
    end

    // Mid-stream reset discards partial config and clears outputs immediately
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 4'h7, 4'h2);
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 4'h3, 4'h9);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_a", ifr.out_a, 0);
    check("mid_rst_out_b", ifr.out_b, 0);
    check("mid_rst_out_valid", ifr.out_valid, 0);
    check("mid_rst_sdo", ifr.cfg_sdo, 0);
    check("mid_rst_ready", ifr.cfg_ready, 0);
    model_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    data_check("post_rst", 4'hA, 4'h5, 4'hA, 4'h5);
    check("post_rst_valid", ifr.out_valid, 1'b1);

    // Short load (5 bits) and overrun load (9 bits) are rejected
    load_modes(8'b01010101);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    check("short_err", ifr.cfg_err, 1'b1);
    data_check("short_keep", 4'hC, 4'h3, 4'h3, 4'hC);
    check("short_err_pulse", ifr.cfg_err, 1'b0);
    for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0, '0, '0);
    check("ovr_not_ready", ifr.cfg_ready, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    check("ovr_err", ifr.cfg_err, 1'b1);
    data_check("ovr_keep", 4'hC, 4'h3, 4'h3, 4'hC);

    // Shift and load together at count 7: shift wins, no error, later load succeeds
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
    check("simul_ready", ifr.cfg_ready, 1'b1);
    check("simul_no_err", ifr.cfg_err, 1'b0);
    data_check("simul_no_load", 4'hC, 4'h3, 4'h3, 4'hC);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    check("simul_then_load_ok", ifr.cfg_err, 1'b0);
    data_check("simul_new_pass", 4'hC, 4'h3, 4'hC, 4'h3);

    // Streaming with toggling valid while a BCA load lands
    for (int i = 7; i >= 0; i--) cycle(1'b1, 1'b0, i[0] ? 1'b1 : 1'b0, i[0], 4'($urandom), 4'($urandom));
    for (int i = 0; i < 8; i++) cycle(1'b0, i == 3, 1'b0, i[0], 4'($urandom), 4'($urandom));

    // Randomised run against the model
    for (int i = 0; i < 3000; i++) begin
      bit sh, ld;
      sh = ($urandom_range(0, 3) != 0);
      ld = (cnt == 2*N) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0);
      if (cnt == 2*N && ld) sh = ($urandom_range(0, 7) == 0);
      cycle(sh, ld, 1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
